// File: rtl/pc_reg.sv
// Program-counter register for the IF stage: holds the fetch address, loads on PC_write, holds on stall.
// Optional macro PC_ALIGN_CHECK_EN word-aligns loaded values and reports misaligned loads.
module pc_reg #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_write,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misalign
);

  logic [WIDTH-1:0] load_value;
  logic             load_misalign;

`ifdef PC_ALIGN_CHECK_EN
  // The low two bits are dropped from the address but remembered in the flag.
  assign load_value    = {pc_in[WIDTH-1:2], 2'b00};
  assign load_misalign = |pc_in[1:0];
`else
  assign load_value    = pc_in;
  assign load_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_out   <= RESET_VECTOR;
      misalign <= 1'b0;
    end else if (PC_write) begin
      pc_out   <= load_value;
      misalign <= load_misalign;
    end
  end

  // Sequential successor wraps modulo 2^WIDTH; carry out is discarded.
  assign pc_plus4 = pc_out + WIDTH'(INC);

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed scenarios plus random traffic against a behavioural model.
module tb_pc_reg;

  localparam int          WIDTH = 32;
  localparam int          INC   = 4;
  localparam logic [31:0] RV    = 32'h0;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_write;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  // Behavioural expectation of the architectural PC and the misalign flag.
  logic [31:0] exp_pc;
  logic        exp_mis;

  pc_reg #(.WIDTH(WIDTH), .RESET_VECTOR(RV), .INC(INC)) dut (
    .clk(clk), .rst(rst), .PC_write(PC_write), .pc_in(pc_in),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance past the edge and update the model.
  task automatic drive(input logic r, input logic w, input logic [31:0] d);
    longint unsigned v;
    rst = r; PC_write = w; pc_in = d;
    @(posedge clk); #1;
    v = longint'(d);
    if (!r) begin
      exp_pc = RV; exp_mis = 1'b0;
    end else if (w) begin
      if (ALIGN) begin
        exp_pc  = 32'(v - (v % 4));
        exp_mis = (v % 4) != 0;
      end else begin
        exp_pc  = d;
        exp_mis = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] succ(input logic [31:0] p);
    return 32'((longint'(p) + INC) % 64'h1_0000_0000);
  endfunction

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (pc_out !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'd0); end
    checks++;
    if (pc_plus4 !== 32'd4) begin failures++; $display("FAIL reset_plus4 got=%h exp=%h", pc_plus4, 32'd4); end
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", misalign); end
    // Leaving reset with PC_write low must not load pc_in.
    drive(1'b1, 1'b0, 32'h55);
    checks++;
    if (pc_out !== 32'd0) begin failures++; $display("FAIL reset_exit_noload got=%h exp=%h", pc_out, 32'd0); end
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 32'd100);
    checks++;
    if (pc_out !== 32'd100) begin failures++; $display("FAIL load_pc got=%0d exp=100", pc_out); end
    checks++;
    if (pc_plus4 !== 32'd104) begin failures++; $display("FAIL load_plus4 got=%0d exp=104", pc_plus4); end
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL load_mis got=%b exp=0", misalign); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'd200);
      checks++;
      if (pc_out !== 32'd100) begin failures++; $display("FAIL stall_%0d got=%0d exp=100", i, pc_out); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    seq[0] = 32'd0; seq[1] = 32'd200; seq[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, seq[i]);
      checks++;
      if (pc_out !== seq[i]) begin failures++; $display("FAIL b2b_%0d got=%0d exp=%0d", i, pc_out, seq[i]); end
    end
    drive(1'b0, 1'b1, 32'd200);
    checks++;
    if (pc_out !== RV) begin failures++; $display("FAIL reset_priority got=%h exp=%h", pc_out, RV); end
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL reset_priority_mis got=%b exp=0", misalign); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    checks++;
    if (pc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=FFFFFFFC", pc_out); end
    checks++;
    if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4 got=%h exp=00000000", pc_plus4); end
  endtask

  task automatic test_misalign();
    logic [31:0] want_pc;
    logic        want_mis;
    want_pc  = ALIGN ? 32'd100 : 32'd102;
    want_mis = ALIGN;
    drive(1'b1, 1'b1, 32'd102);
    checks++;
    if (pc_out !== want_pc) begin failures++; $display("FAIL misalign_pc got=%0d exp=%0d", pc_out, want_pc); end
    checks++;
    if (misalign !== want_mis) begin failures++; $display("FAIL misalign_flag got=%b exp=%b", misalign, want_mis); end
    // Flag must hold through a stall and clear on an aligned load.
    drive(1'b1, 1'b0, 32'd7);
    checks++;
    if (misalign !== want_mis) begin failures++; $display("FAIL misalign_hold got=%b exp=%b", misalign, want_mis); end
    drive(1'b1, 1'b1, 32'd8);
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", misalign); end
  endtask

  task automatic test_random();
    logic        r, w;
    logic [31:0] d;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) != 0);
      w = ($urandom_range(0, 2) != 0);
      d = $urandom();
      if ($urandom_range(0, 9) == 0) d = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      drive(r, w, d);
      checks++;
      if (pc_out !== exp_pc) begin failures++; $display("FAIL rand_pc_%0d got=%h exp=%h", i, pc_out, exp_pc); end
      checks++;
      if (pc_plus4 !== succ(exp_pc)) begin failures++; $display("FAIL rand_plus4_%0d got=%h exp=%h", i, pc_plus4, succ(exp_pc)); end
      checks++;
      if (misalign !== exp_mis) begin failures++; $display("FAIL rand_mis_%0d got=%b exp=%b", i, misalign, exp_mis); end
    end
  endtask

  initial begin
    rst = 1'b1; PC_write = 1'b0; pc_in = 32'h0;
    exp_pc = 32'hx; exp_mis = 1'bx;
    @(posedge clk); #1;
    test_reset();
    test_load();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
